// File: rtl/branch_update_unit.sv
// Resolves EX branches against the fetch prediction. It issues a registered redirect, holds a flush, and queues BTB updates.
// Redirect and update appear 1 cycle after the branch is accepted. Resolutions are ignored during flush. An update that meets a full queue with no dequeue in the same cycle is dropped.
module branch_update_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resValid,
  input  logic [31:0]          resPC,
  input  logic                 resTaken,
  input  logic [31:0]          resTarget,
  input  logic                 predHit,
  input  logic [31:0]          predTarget,
  input  logic                 updReady,
  output logic                 redirectValid,
  output logic [31:0]          redirectPC,
  output logic                 flush,
  output logic                 updValid,
  output logic [31:0]          updPC,
  output logic [31:0]          updTarget,
  output logic                 updRemove,
  output logic                 queueFull,
  output logic [CNT_WIDTH-1:0] branchCount,
  output logic [CNT_WIDTH-1:0] mispredictCount,
  output logic [CNT_WIDTH-1:0] dropCount
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [FCW-1:0]    fcnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [31:0]       mem_pc  [DEPTH];
  logic [31:0]       mem_tgt [DEPTH];
  logic              mem_rem [DEPTH];

  logic              accept;
  logic              mis;
  logic [31:0]       redir_pc;
  logic [31:0]       new_tgt;
  logic              new_rem;
  logic              enq_req;
  logic              enq;
  logic              deq;
  logic              drop;

  assign accept = resValid && (state == IDLE);

  // A predicted-taken branch that falls through becomes a remove; every other miss inserts the real target.
  always_comb begin
    mis      = 1'b0;
    redir_pc = resTarget;
    new_tgt  = resTarget;
    new_rem  = 1'b0;
    if (predHit && !resTaken) begin
      mis      = 1'b1;
      redir_pc = resPC + 32'd4;
      new_tgt  = 32'd0;
      new_rem  = 1'b1;
    end else if (!predHit && resTaken) begin
      mis = 1'b1;
    end else if (predHit && resTaken && (predTarget != resTarget)) begin
      mis = 1'b1;
    end
  end

  assign enq_req = accept && mis;
  assign deq     = updValid && updReady;
  assign enq     = enq_req && (!queueFull || deq);
  assign drop    = enq_req && !enq;

  always_comb begin
    count_next = count;
    if (enq && !deq)
      count_next = count + CW'(1);
    else if (!enq && deq)
      count_next = count - CW'(1);
  end

  assign updPC     = mem_pc[rd_ptr];
  assign updTarget = mem_tgt[rd_ptr];
  assign updRemove = mem_rem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fcnt          <= '0;
      flush         <= 1'b0;
      redirectValid <= 1'b0;
      redirectPC    <= 32'd0;
    end else begin
      redirectValid <= enq_req;
      if (enq_req)
        redirectPC <= redir_pc;
      case (state)
        IDLE: begin
          if (enq_req) begin
            state <= FLUSH;
            fcnt  <= FCW'(FLUSH_CYCLES);
            flush <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt == FCW'(1)) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            fcnt <= fcnt - FCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Entries are cleared on reset so the head reads zero while the queue is empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      updValid  <= 1'b0;
      queueFull <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]  <= 32'd0;
        mem_tgt[i] <= 32'd0;
        mem_rem[i] <= 1'b0;
      end
    end else begin
      if (enq) begin
        mem_pc[wr_ptr]  <= resPC;
        mem_tgt[wr_ptr] <= new_tgt;
        mem_rem[wr_ptr] <= new_rem;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (deq)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      updValid  <= (count_next != '0);
      queueFull <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branchCount     <= '0;
      mispredictCount <= '0;
      dropCount       <= '0;
    end else begin
      if (accept && (branchCount != {CNT_WIDTH{1'b1}}))
        branchCount <= branchCount + CNT_WIDTH'(1);
      if (enq_req && (mispredictCount != {CNT_WIDTH{1'b1}}))
        mispredictCount <= mispredictCount + CNT_WIDTH'(1);
      if (drop && (dropCount != {CNT_WIDTH{1'b1}}))
        dropCount <= dropCount + CNT_WIDTH'(1);
    end
  end

endmodule
